lcd_text_buffer_ctrl: RTL and testbench

LCD_TEXT_BUFFER_CTRL -- requirements
Module: lcd_text_buffer_ctrl

---
 rtl/lcd_text_buffer_ctrl_if.sv | 50 +++++
 rtl/lcd_text_buffer_ctrl.sv | 122 ++++++++++++
 tb/tb_lcd_text_buffer_ctrl.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_buffer_ctrl_if.sv
// Bundle of the display-read, host-write and character-RAM signals of the
// LCD text buffer controller.
//   slave  : the controller side (lcd_text_buffer_ctrl)
//   master : the environment side (font stage, host, RAM)
// Signals:
//   disp_req/disp_column/disp_row        display read request and coordinates
//   disp_character/disp_valid            read result, two cycles after request
//   host_valid/host_ready                host write handshake
//   host_column/host_row/host_character  host write coordinates and data
//   host_clear                           clear-screen request
//   busy                                 clear sequence in progress
//   ram_address/ram_write_enable/ram_write_data/ram_read_data  RAM port
interface lcd_text_buffer_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  disp_req;
    logic [6:0]            disp_column;
    logic [5:0]            disp_row;
    logic [6:0]            disp_character;
    logic                  disp_valid;
    logic                  host_valid;
    logic                  host_ready;
    logic [6:0]            host_column;
    logic [5:0]            host_row;
    logic [6:0]            host_character;
    logic                  host_clear;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_write_enable;
    logic [6:0]            ram_write_data;
    logic [6:0]            ram_read_data;

    modport slave (
        input  disp_req, disp_column, disp_row,
        output disp_character, disp_valid,
        input  host_valid, host_column, host_row, host_character, host_clear,
        output host_ready, busy,
        output ram_address, ram_write_enable, ram_write_data,
        input  ram_read_data
    );

    modport master (
        output disp_req, disp_column, disp_row,
        input  disp_character, disp_valid,
        output host_valid, host_column, host_row, host_character, host_clear,
        input  host_ready, busy,
        input  ram_address, ram_write_enable, ram_write_data,
        output ram_read_data
    );
endinterface

// File: rtl/lcd_text_buffer_ctrl.sv
// LCD text buffer controller: shares one single-port character RAM between
// display reads (highest priority), the clear-screen sweep and host writes.
// Display reads answer at a fixed latency of 2 cycles.
// Ports:
//   clock  system clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    lcd_text_buffer_ctrl_if.slave (display, host and RAM signals)
module lcd_text_buffer_ctrl #(
    parameter int unsigned COLUMNS    = 25,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic                   clock,
    input logic                   reset,
    lcd_text_buffer_ctrl_if.slave bus
);
    localparam logic [6:0]            Space    = 7'h20;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(ROWS * COLUMNS - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_count_q, clear_count_d;
    logic                  rd_pend_q, rd_pend_d;    // read issued last cycle
    logic                  rd_oor_q, rd_oor_d;      // that read was out of range
    logic                  disp_valid_q, disp_valid_d;
    logic [6:0]            disp_char_q, disp_char_d;

    logic                  disp_in_range, host_in_range;
    logic [ADDR_WIDTH-1:0] disp_addr, host_addr;
    logic                  host_ready;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_write_enable;
    logic [6:0]            ram_write_data;

    assign disp_in_range = (32'(bus.disp_column) < COLUMNS) && (32'(bus.disp_row) < ROWS);
    assign host_in_range = (32'(bus.host_column) < COLUMNS) && (32'(bus.host_row) < ROWS);
    assign disp_addr = ADDR_WIDTH'(32'(bus.disp_row) * COLUMNS + 32'(bus.disp_column));
    assign host_addr = ADDR_WIDTH'(32'(bus.host_row) * COLUMNS + 32'(bus.host_column));

    always_comb begin
        state_d          = state_q;
        clear_count_d    = clear_count_q;
        rd_pend_d        = 1'b0;
        rd_oor_d         = 1'b0;
        disp_valid_d     = 1'b0;
        disp_char_d      = disp_char_q;
        ram_address      = '0;
        ram_write_enable = 1'b0;
        ram_write_data   = 7'h00;

        host_ready = ~reset & (state_q == StIdle) & ~bus.disp_req & ~bus.host_clear;

        // RAM port arbitration: display read > clear write > host write.
        // Nothing touches the RAM while reset is held.
        if (!reset) begin
            if (bus.disp_req) begin
                rd_pend_d = 1'b1;
                rd_oor_d  = ~disp_in_range;
                if (disp_in_range) begin
                    ram_address = disp_addr;
                end
            end else if (state_q == StClear) begin
                ram_address      = clear_count_q;
                ram_write_enable = 1'b1;
                ram_write_data   = Space;
            end else if (bus.host_valid && host_ready && host_in_range) begin
                ram_address      = host_addr;
                ram_write_enable = 1'b1;
                ram_write_data   = bus.host_character;
            end
        end

        // Second pipeline stage: RAM data is valid now, register it for N+2.
        if (rd_pend_q) begin
            disp_valid_d = 1'b1;
            disp_char_d  = rd_oor_q ? Space : bus.ram_read_data;
        end

        if (state_q == StClear) begin
            if (bus.host_clear) begin
                clear_count_d = '0;
            end else if (!bus.disp_req) begin
                if (clear_count_q == LastAddr) begin
                    state_d       = StIdle;
                    clear_count_d = '0;
                end else begin
                    clear_count_d = clear_count_q + 1'b1;
                end
            end
        end else if (bus.host_clear) begin
            state_d       = StClear;
            clear_count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StClear;
            clear_count_q <= '0;
            rd_pend_q     <= 1'b0;
            rd_oor_q      <= 1'b0;
            disp_valid_q  <= 1'b0;
            disp_char_q   <= Space;
        end else begin
            state_q       <= state_d;
            clear_count_q <= clear_count_d;
            rd_pend_q     <= rd_pend_d;
            rd_oor_q      <= rd_oor_d;
            disp_valid_q  <= disp_valid_d;
            disp_char_q   <= disp_char_d;
        end
    end

    assign bus.disp_valid       = disp_valid_q;
    assign bus.disp_character   = disp_char_q;
    assign bus.busy             = (state_q == StClear);
    assign bus.host_ready       = host_ready;
    assign bus.ram_address      = ram_address;
    assign bus.ram_write_enable = ram_write_enable;
    assign bus.ram_write_data   = ram_write_data;
endmodule

// File: tb/tb_lcd_text_buffer_ctrl.sv
// Self-checking bench for lcd_text_buffer_ctrl. A behavioural screen model
// (flat array of characters indexed row*COLUMNS+column) predicts every read.
module tb_lcd_text_buffer_ctrl;
    localparam int C     = 25;
    localparam int R     = 8;
    localparam int AW    = 8;
    localparam int CELLS = C * R;

    typedef struct {
        int         due;
        logic [6:0] ch;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [6:0] mem    [0:(1<<AW)-1];
    logic [6:0] screen [0:CELLS-1];
    exp_t       expq   [$];

    lcd_text_buffer_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    lcd_text_buffer_ctrl #(
        .COLUMNS   (C),
        .ROWS      (R),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Character RAM: registered read, data valid one cycle after the address.
    always @(posedge clock) begin
        if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_write_data;
        bus.ram_read_data <= mem[bus.ram_address];
    end

    function automatic logic in_rng(int c, int r);
        return (c < C) && (r < R);
    endfunction

    function automatic int lin(int c, int r);
        return r * C + c;
    endfunction

    task automatic idle_inputs();
        bus.disp_req       = 1'b0;
        bus.disp_column    = 7'd0;
        bus.disp_row       = 6'd0;
        bus.host_valid     = 1'b0;
        bus.host_column    = 7'd0;
        bus.host_row       = 6'd0;
        bus.host_character = 7'd0;
        bus.host_clear     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.disp_req   = 1'($urandom_range(0, 1));
            bus.host_valid = 1'($urandom_range(0, 1));
            bus.host_clear = 1'($urandom_range(0, 1));
            @(negedge clock);
            total++;
            if ({bus.busy, bus.host_ready, bus.ram_write_enable, bus.disp_valid,
                 bus.disp_character} !== {4'b1000, 7'h20}) begin
                bad++;
                $display("FAIL reset_state got=%b want=%b", {bus.busy, bus.host_ready,
                         bus.ram_write_enable, bus.disp_valid, bus.disp_character},
                         {4'b1000, 7'h20});
            end
        end
    endtask

    // Expects a clear sweep starting at address 0 in the current cycle.
    task automatic run_clear(input string name);
        int k = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!bus.busy) break;
            total++;
            if ({bus.ram_write_enable, bus.ram_address, bus.ram_write_data} !==
                {1'b1, 8'(k), 7'h20}) begin
                bad++;
                $display("FAIL %s_write got=%b/%0d/%h want=1/%0d/20", name,
                         bus.ram_write_enable, bus.ram_address, bus.ram_write_data, k);
            end
            k++;
            next_cycle();
        end
        total++;
        if (k !== CELLS) begin
            bad++;
            $display("FAIL %s_length got=%0d want=%0d", name, k, CELLS);
        end
        total++;
        if ({bus.busy, bus.host_ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s_done got busy/ready=%b want=01", name, {bus.busy, bus.host_ready});
        end
        for (int i = 0; i < CELLS; i++) screen[i] = 7'h20;
    endtask

    task automatic test_clear_sequence();
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        run_clear("clear_seq");
    endtask

    task automatic test_write_then_read();
        next_cycle();
        bus.host_valid = 1'b1; bus.host_column = 7'd3; bus.host_row = 6'd2;
        bus.host_character = 7'h41;
        @(negedge clock);
        total++;
        if ({bus.host_ready, bus.ram_write_enable, bus.ram_address, bus.ram_write_data} !==
            {2'b11, 8'd53, 7'h41}) begin
            bad++;
            $display("FAIL wr_host got=%b/%b/%0d/%h want=1/1/53/41", bus.host_ready,
                     bus.ram_write_enable, bus.ram_address, bus.ram_write_data);
        end
        screen[53] = 7'h41;
        next_cycle();
        idle_inputs();
        bus.disp_req = 1'b1; bus.disp_column = 7'd3; bus.disp_row = 6'd2;
        @(negedge clock);
        total++;
        if ({bus.ram_write_enable, bus.ram_address} !== {1'b0, 8'd53}) begin
            bad++;
            $display("FAIL wr_read_addr got=%b/%0d want=0/53", bus.ram_write_enable,
                     bus.ram_address);
        end
        next_cycle();
        idle_inputs();
        @(negedge clock);
        total++;
        if (bus.disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL wr_early_valid got=%b want=0", bus.disp_valid);
        end
        next_cycle();
        @(negedge clock);
        total++;
        if ({bus.disp_valid, bus.disp_character} !== {1'b1, 7'h41}) begin
            bad++;
            $display("FAIL wr_read_data got=%b/%h want=1/41", bus.disp_valid, bus.disp_character);
        end
        next_cycle();
        @(negedge clock);
        total++;
        if (bus.disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL wr_valid_pulse got=%b want=0", bus.disp_valid);
        end
    endtask

    task automatic test_collision();
        int         dc  = $urandom_range(0, C - 1);
        int         dr  = $urandom_range(0, R - 1);
        int         hc  = $urandom_range(0, C - 1);
        int         hr  = $urandom_range(0, R - 1);
        logic [6:0] hch = 7'($urandom);
        logic [6:0] exp_ch = screen[lin(dc, dr)];
        next_cycle();
        bus.disp_req = 1'b1; bus.disp_column = 7'(dc); bus.disp_row = 6'(dr);
        bus.host_valid = 1'b1; bus.host_column = 7'(hc); bus.host_row = 6'(hr);
        bus.host_character = hch;
        @(negedge clock);
        total++;
        if ({bus.host_ready, bus.ram_write_enable, bus.ram_address} !==
            {2'b00, 8'(lin(dc, dr))}) begin
            bad++;
            $display("FAIL coll_read got=%b/%b/%0d want=0/0/%0d", bus.host_ready,
                     bus.ram_write_enable, bus.ram_address, lin(dc, dr));
        end
        next_cycle();
        bus.disp_req = 1'b0;
        @(negedge clock);
        total++;
        if ({bus.host_ready, bus.ram_write_enable, bus.ram_address, bus.ram_write_data} !==
            {2'b11, 8'(lin(hc, hr)), hch}) begin
            bad++;
            $display("FAIL coll_write got=%b/%b/%0d/%h want=1/1/%0d/%h", bus.host_ready,
                     bus.ram_write_enable, bus.ram_address, bus.ram_write_data, lin(hc, hr), hch);
        end
        screen[lin(hc, hr)] = hch;
        next_cycle();
        idle_inputs();
        @(negedge clock);
        total++;
        if ({bus.disp_valid, bus.disp_character} !== {1'b1, exp_ch}) begin
            bad++;
            $display("FAIL coll_data got=%b/%h want=1/%h", bus.disp_valid, bus.disp_character,
                     exp_ch);
        end
    endtask

    task automatic test_out_of_range();
        next_cycle();
        bus.disp_req = 1'b1; bus.disp_column = 7'd30; bus.disp_row = 6'd0;
        @(negedge clock);
        total++;
        if ({bus.ram_write_enable, bus.ram_address} !== {1'b0, 8'd0}) begin
            bad++;
            $display("FAIL oor_read got=%b/%0d want=0/0", bus.ram_write_enable, bus.ram_address);
        end
        next_cycle();
        idle_inputs();
        bus.host_valid = 1'b1; bus.host_column = 7'd0; bus.host_row = 6'd9;
        bus.host_character = 7'h55;
        @(negedge clock);
        total++;
        if ({bus.host_ready, bus.ram_write_enable, bus.ram_address} !== {2'b10, 8'd0}) begin
            bad++;
            $display("FAIL oor_write got=%b/%b/%0d want=1/0/0", bus.host_ready,
                     bus.ram_write_enable, bus.ram_address);
        end
        next_cycle();
        idle_inputs();
        @(negedge clock);
        total++;
        if ({bus.disp_valid, bus.disp_character} !== {1'b1, 7'h20}) begin
            bad++;
            $display("FAIL oor_data got=%b/%h want=1/20", bus.disp_valid, bus.disp_character);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 11; i++) begin
            next_cycle();
            idle_inputs();
            if (i < 8) begin
                int c = $urandom_range(0, 27);
                int r = $urandom_range(0, 8);
                exp_t e;
                bus.disp_req = 1'b1; bus.disp_column = 7'(c); bus.disp_row = 6'(r);
                e.due = cyc + 2;
                e.ch  = in_rng(c, r) ? screen[lin(c, r)] : 7'h20;
                expq.push_back(e);
            end
            @(negedge clock);
            total++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if ({bus.disp_valid, bus.disp_character} !== {1'b1, expq[0].ch}) begin
                    bad++;
                    $display("FAIL b2b_data cyc=%0d got=%b/%h want=1/%h", cyc, bus.disp_valid,
                             bus.disp_character, expq[0].ch);
                end
                void'(expq.pop_front());
            end else if (bus.disp_valid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_valid cyc=%0d got=%b want=0", cyc, bus.disp_valid);
            end
        end
    endtask

    task automatic test_random_mix();
        logic       hold = 1'b0;
        logic       hv = 1'b0;
        int         hc = 0, hr = 0;
        logic [6:0] hch = 7'h0;
        for (int t = 0; t < 303; t++) begin
            logic                   dreq;
            int                     dc, dr;
            logic                   exp_ready;
            logic [1+AW+7-1:0]      exp_ram;
            next_cycle();
            dreq = (t < 300) && ($urandom_range(0, 2) == 0);
            dc   = $urandom_range(0, 29);
            dr   = $urandom_range(0, 9);
            if (!hold) begin
                hv  = (t < 300) && ($urandom_range(0, 1) == 1);
                hc  = $urandom_range(0, 27);
                hr  = $urandom_range(0, 8);
                hch = 7'($urandom);
            end
            bus.disp_req = dreq; bus.disp_column = 7'(dc); bus.disp_row = 6'(dr);
            bus.host_valid = hv; bus.host_column = 7'(hc); bus.host_row = 6'(hr);
            bus.host_character = hch; bus.host_clear = 1'b0;
            exp_ready = !dreq;
            if (dreq) begin
                exp_t e;
                e.due = cyc + 2;
                e.ch  = in_rng(dc, dr) ? screen[lin(dc, dr)] : 7'h20;
                expq.push_back(e);
                exp_ram = {1'b0, in_rng(dc, dr) ? 8'(lin(dc, dr)) : 8'd0, 7'h0};
            end else if (hv && in_rng(hc, hr)) begin
                exp_ram = {1'b1, 8'(lin(hc, hr)), hch};
            end else begin
                exp_ram = '0;
            end
            @(negedge clock);
            total++;
            if (bus.host_ready !== exp_ready) begin
                bad++;
                $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, bus.host_ready, exp_ready);
            end
            total++;
            if ({bus.ram_write_enable, bus.ram_address,
                 bus.ram_write_enable ? bus.ram_write_data : 7'h0} !== exp_ram) begin
                bad++;
                $display("FAIL rand_ram cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", cyc,
                         bus.ram_write_enable, bus.ram_address, bus.ram_write_data,
                         exp_ram[15], exp_ram[14:7], exp_ram[6:0]);
            end
            total++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if ({bus.disp_valid, bus.disp_character} !== {1'b1, expq[0].ch}) begin
                    bad++;
                    $display("FAIL rand_data cyc=%0d got=%b/%h want=1/%h", cyc, bus.disp_valid,
                             bus.disp_character, expq[0].ch);
                end
                void'(expq.pop_front());
            end else if (bus.disp_valid !== 1'b0) begin
                bad++;
                $display("FAIL rand_valid cyc=%0d got=%b want=0", cyc, bus.disp_valid);
            end
            if (hv && exp_ready && in_rng(hc, hr)) screen[lin(hc, hr)] = hch;
            hold = hv && !exp_ready;
        end
        idle_inputs();
    endtask

    task automatic test_clear_with_reads();
        int k = 0, busy_cycles = 0;
        next_cycle();
        idle_inputs();
        bus.host_clear = 1'b1;
        @(negedge clock);
        total++;
        if (bus.host_ready !== 1'b0) begin
            bad++;
            $display("FAIL cr_ready got=%b want=0", bus.host_ready);
        end
        for (int i = 0; i < 410; i++) begin
            logic dreq = (i % 2 == 0) && (i <= 400);
            next_cycle();
            idle_inputs();
            if (dreq) begin
                int c = $urandom_range(0, C - 1);
                int r = $urandom_range(0, R - 1);
                exp_t e;
                bus.disp_req = 1'b1; bus.disp_column = 7'(c); bus.disp_row = 6'(r);
                e.due = cyc + 2;
                e.ch  = screen[lin(c, r)];
                expq.push_back(e);
            end
            @(negedge clock);
            if (bus.busy) begin
                busy_cycles++;
                if (!dreq) begin
                    total++;
                    if ({bus.ram_write_enable, bus.ram_address, bus.ram_write_data} !==
                        {1'b1, 8'(k), 7'h20}) begin
                        bad++;
                        $display("FAIL cr_write got=%b/%0d/%h want=1/%0d/20",
                                 bus.ram_write_enable, bus.ram_address, bus.ram_write_data, k);
                    end
                    if (k < CELLS) screen[k] = 7'h20;
                    k++;
                end
            end
            total++;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                if ({bus.disp_valid, bus.disp_character} !== {1'b1, expq[0].ch}) begin
                    bad++;
                    $display("FAIL cr_data cyc=%0d got=%b/%h want=1/%h", cyc, bus.disp_valid,
                             bus.disp_character, expq[0].ch);
                end
                void'(expq.pop_front());
            end else if (bus.disp_valid !== 1'b0) begin
                bad++;
                $display("FAIL cr_valid cyc=%0d got=%b want=0", cyc, bus.disp_valid);
            end
        end
        // 200 writes interleaved with 200 stalled request cycles.
        total++;
        if (busy_cycles !== 2 * CELLS || k !== CELLS) begin
            bad++;
            $display("FAIL cr_length got busy=%0d writes=%0d want busy=%0d writes=%0d",
                     busy_cycles, k, 2 * CELLS, CELLS);
        end
    endtask

    task automatic test_clear_restart();
        next_cycle();
        idle_inputs();
        bus.host_clear = 1'b1;
        for (int k = 0; k < 100; k++) begin
            next_cycle();
            bus.host_clear = 1'b0;
            @(negedge clock);
            total++;
            if ({bus.ram_write_enable, bus.ram_address} !== {1'b1, 8'(k)}) begin
                bad++;
                $display("FAIL rs_first got=%b/%0d want=1/%0d", bus.ram_write_enable,
                         bus.ram_address, k);
            end
        end
        next_cycle();
        bus.host_clear = 1'b1;
        @(negedge clock);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL rs_busy got=%b want=1", bus.busy);
        end
        next_cycle();
        bus.host_clear = 1'b0;
        run_clear("restart");
    endtask

    task automatic test_reset_midway();
        next_cycle();
        idle_inputs();
        bus.disp_req = 1'b1; bus.disp_column = 7'd1; bus.disp_row = 6'd1;
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({bus.ram_write_enable, bus.host_ready} !== 2'b00) begin
            bad++;
            $display("FAIL rm_quiet got=%b want=00", {bus.ram_write_enable, bus.host_ready});
        end
        next_cycle();
        @(negedge clock);
        total++;
        if ({bus.disp_valid, bus.busy, bus.disp_character} !== {2'b01, 7'h20}) begin
            bad++;
            $display("FAIL rm_flush got=%b want=%b", {bus.disp_valid, bus.busy,
                     bus.disp_character}, {2'b01, 7'h20});
        end
        next_cycle();
        reset = 1'b0;
        run_clear("reset_mid");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_clear_sequence();
        test_write_then_read();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_random_mix();
        test_clear_with_reads();
        test_clear_restart();
        test_write_then_read();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
